vector_sequencer: RTL and testbench
===================================

Name: vector_sequencer

Overview:
- Synthesizable self-test controller that stores a table of input/expected-output vectors and applies them, one by one, to a small combinational DUT (e.g. a 3-input/1-output function block).
- Compares the DUT response to each expected value and counts mismatches.
- Captures the index of the first failing vector and reports pass/fail.
- Sits beside the DUT on-chip and replaces a simulation-only vector testbench for in-silicon or FPGA checking.

Parameters:
- IN_W, 3, DUT input width.
- OUT_W, 1, DUT output width.
- DEPTH, 16, vector table entries (power of 2, >=2).
- ADDR_W, $clog2(DEPTH), table index width.
- CNT_W, $clog2(DEPTH+1), width of the vector count and error count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  write one vector into the table.
- load_data  in  IN_W+OUT_W  vector, packed as {inputs, expected}; inputs in the MSBs.
- load_ready  out  1  table can accept a vector.
- clear  in  1  empty the table (vec_count := 0).
- start  in  1  begin a run.
- abort  in  1  stop a run in progress.
- dut_in  out  IN_W  registered stimulus to the DUT.
- dut_out  in  OUT_W  DUT response; combinational from dut_in.
- busy  out  1  run in progress.
- done  out  1  run completed; held until the next start/load/clear.
- pass  out  1  valid while done; 1 iff err_count==0.
- err_pulse  out  1  one-cycle pulse on each mismatch.
- err_count  out  CNT_W  number of mismatches in the current/last run.
- first_err_idx  out  ADDR_W  index of the first mismatching vector.
- first_err_valid  out  1  first_err_idx holds a captured index.
- vec_count  out  CNT_W  number of vectors loaded.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; table contents are not reset (table is empty via vec_count=0).
- FSM states: IDLE, APPLY, CHECK, DONE.
- Load path (IDLE or DONE only):
  - load_ready = (state is IDLE or DONE) && vec_count<DEPTH.
  - When load_valid && load_ready: mem[vec_count] := load_data and vec_count++.
  - A load from DONE moves the FSM to IDLE; done and pass drop.
  - load_valid while load_ready=0 is dropped silently.
- clear (IDLE or DONE): vec_count := 0, FSM to IDLE.
  - clear and load in the same cycle: clear wins, the load is dropped.
  - clear is ignored during APPLY/CHECK.
- start (IDLE or DONE, vec_count>0): the following are set on the same edge:
  - idx := 0
  - err_count := 0
  - first_err_valid := 0
  - dut_in := mem[0].inputs
  - FSM to APPLY; busy=1, done=0.
- start with vec_count==0 is ignored; start during a run is ignored.
- Precedence in the same cycle: clear > start > load.
- APPLY (1 cycle): dut_in is stable so the DUT settles. Next state is CHECK.
- CHECK (1 cycle): compare dut_out with mem[idx].expected.
  - On mismatch: err_pulse=1 this cycle (combinational from CHECK and the compare) and err_count++.
  - On the first mismatch also: first_err_idx := idx and first_err_valid := 1.
  - If idx==vec_count-1: FSM to DONE, busy := 0, done := 1, pass := (final err_count==0).
  - Otherwise: idx++, dut_in := mem[idx+1].inputs, FSM to APPLY.
- Timing: 2 cycles per vector. With start sampled at edge 0, done rises at edge 2N.
- abort during APPLY/CHECK: FSM to IDLE, busy := 0, done := 0. err_count and first_err_* are frozen and remain readable. dut_in holds its value.
- err_count cannot overflow, since CNT_W covers DEPTH.
- Asynchronous reset mid-run: immediate return to the reset values; the table must be reloaded.

Decomposition:
- Package vseq_pkg holds:
  - enum vseq_state_t {IDLE, APPLY, CHECK, DONE}
  - localparam defaults for IN_W, OUT_W, DEPTH
  - helper to pack/unpack {inputs, expected}
- Sub-module vseq_vector_mem: DEPTH x (IN_W+OUT_W) register file with one synchronous write port and one combinational read port addressed by idx. It has no reset.
- The FSM, counters and compare logic live in vector_sequencer.

Test Plan:
- Full-truth-table pass: load 8 vectors with a correct DUT, y = ~b&~c | a&~b, expected values {1,0,0,0,1,1,0,0} at abc=000..111, then start. Required: dut_in steps 000..111 on alternate cycles, done at start+16 cycles, err_count=0, pass=1, first_err_valid=0.
- Fault injection: same table with index 5 expected flipped to 0. Required: one err_pulse, in the CHECK cycle of idx 5; err_count=1; first_err_idx=5; pass=0.
- Table full: load 16 vectors. Required: vec_count=16 and load_ready=0; a 17th load_valid leaves vec_count at 16 and mem unchanged.
- Empty/ignored start: start with vec_count=0 keeps IDLE, busy=0, done=0. start pulsed mid-run has no effect on idx or err_count.
- Abort and rerun: 8 vectors with a fault at index 1, abort asserted at idx 3. Required: next cycle IDLE, busy=0, done=0, err_count=1, first_err_idx=1. A new start clears err_count to 0 and the rerun completes with err_count=1.
- Reset and clear: reset asserted mid-run gives all outputs 0 immediately and vec_count=0. clear and load_valid asserted together in DONE give vec_count=0 and state IDLE.

Source files
------------

// File: rtl/vseq_pkg.sv
// rtl/vseq_pkg.sv - shared types, default sizes and vector pack helpers for vector_sequencer
package vseq_pkg;
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} vseq_state_t;

    localparam int IN_W_DEF  = 3;
    localparam int OUT_W_DEF = 1;
    localparam int DEPTH_DEF = 16;

    // A table entry is {inputs, expected} with the stimulus in the MSBs.
    function automatic logic [IN_W_DEF+OUT_W_DEF-1:0] vseq_pack(
        input logic [IN_W_DEF-1:0]  vin,
        input logic [OUT_W_DEF-1:0] vexp
    );
        return {vin, vexp};
    endfunction

    function automatic logic [IN_W_DEF-1:0] vseq_inputs(input logic [IN_W_DEF+OUT_W_DEF-1:0] v);
        return v[IN_W_DEF+OUT_W_DEF-1:OUT_W_DEF];
    endfunction

    function automatic logic [OUT_W_DEF-1:0] vseq_expected(input logic [IN_W_DEF+OUT_W_DEF-1:0] v);
        return v[OUT_W_DEF-1:0];
    endfunction
endpackage

// File: rtl/vector_sequencer_if.sv
// rtl/vector_sequencer_if.sv - control, load, status and DUT-side signals of vector_sequencer
interface vector_sequencer_if
    import vseq_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                  load_valid;
    logic [IN_W+OUT_W-1:0] load_data;
    logic                  load_ready;
    logic                  clear;
    logic                  start;
    logic                  abort;
    logic [IN_W-1:0]       dut_in;
    logic [OUT_W-1:0]      dut_out;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  err_pulse;
    logic [CNT_W-1:0]      err_count;
    logic [ADDR_W-1:0]     first_err_idx;
    logic                  first_err_valid;
    logic [CNT_W-1:0]      vec_count;

    // The master side is the host plus the function block under test.
    modport master (
        output load_valid, load_data, clear, start, abort, dut_out,
        input  load_ready, dut_in, busy, done, pass, err_pulse,
               err_count, first_err_idx, first_err_valid, vec_count
    );

    modport slave (
        input  load_valid, load_data, clear, start, abort, dut_out,
        output load_ready, dut_in, busy, done, pass, err_pulse,
               err_count, first_err_idx, first_err_valid, vec_count
    );
endinterface

// File: rtl/vseq_vector_mem.sv
// rtl/vseq_vector_mem.sv - vector table: one synchronous write port, one combinational read port
module vseq_vector_mem
    import vseq_pkg::*;
#(
    parameter int W      = IN_W_DEF + OUT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - applies stored vectors to a combinational DUT and tallies mismatches
module vector_sequencer
    import vseq_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          reset,
    vector_sequencer_if.slave bus
);
    vseq_state_t           r_state;
    logic [ADDR_W-1:0]     r_idx;
    logic [CNT_W-1:0]      r_vec_count;
    logic [CNT_W-1:0]      r_err_count;
    logic [IN_W-1:0]       r_dut_in;
    logic [OUT_W-1:0]      r_exp;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [ADDR_W-1:0]     r_first_err_idx;
    logic                  r_first_err_valid;

    logic                  w_idle_like;
    logic                  w_load_ready;
    logic                  w_start_fire;
    logic                  w_load_fire;
    logic                  w_mismatch;
    logic                  w_last;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic [IN_W+OUT_W-1:0] w_rd_data;

    assign w_idle_like  = (r_state == IDLE) || (r_state == DONE);
    assign w_load_ready = w_idle_like && (r_vec_count < CNT_W'(DEPTH));
    assign w_start_fire = w_idle_like && bus.start && !bus.clear && (r_vec_count != '0);
    assign w_load_fire  = w_load_ready && bus.load_valid && !bus.clear && !w_start_fire;
    assign w_mismatch   = (r_state == CHECK) && (bus.dut_out != r_exp);
    assign w_last       = (CNT_W'(r_idx) == (r_vec_count - CNT_W'(1)));

    // The read port always looks one vector ahead: entry 0 before a run, idx+1 while checking,
    // so stimulus and its expected value are latched together when they are applied.
    assign w_rd_addr = (r_state == CHECK) ? (r_idx + ADDR_W'(1)) : '0;

    vseq_vector_mem #(
        .W      (IN_W + OUT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_load_fire),
        .i_waddr (r_vec_count[ADDR_W-1:0]),
        .i_wdata (bus.load_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= IDLE;
            r_idx             <= '0;
            r_vec_count       <= '0;
            r_err_count       <= '0;
            r_dut_in          <= '0;
            r_exp             <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_first_err_idx   <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.clear) begin
                        r_vec_count <= '0;
                        r_state     <= IDLE;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end else if (w_start_fire) begin
                        r_idx             <= '0;
                        r_err_count       <= '0;
                        r_first_err_valid <= 1'b0;
                        r_dut_in          <= w_rd_data[IN_W+OUT_W-1:OUT_W];
                        r_exp             <= w_rd_data[OUT_W-1:0];
                        r_state           <= APPLY;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                    end else if (w_load_fire) begin
                        r_vec_count <= r_vec_count + CNT_W'(1);
                        r_state     <= IDLE;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                APPLY: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        if (w_mismatch) begin
                            r_err_count <= r_err_count + CNT_W'(1);
                            if (!r_first_err_valid) begin
                                r_first_err_idx   <= r_idx;
                                r_first_err_valid <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_count == '0) && !w_mismatch;
                        end else begin
                            r_idx    <= r_idx + ADDR_W'(1);
                            r_dut_in <= w_rd_data[IN_W+OUT_W-1:OUT_W];
                            r_exp    <= w_rd_data[OUT_W-1:0];
                            r_state  <= APPLY;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.load_ready      = w_load_ready;
    assign bus.dut_in          = r_dut_in;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_pulse       = w_mismatch;
    assign bus.err_count       = r_err_count;
    assign bus.first_err_idx   = r_first_err_idx;
    assign bus.first_err_valid = r_first_err_valid;
    assign bus.vec_count       = r_vec_count;
endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - directed self-checking bench for vector_sequencer
module tb_vector_sequencer;
    import vseq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] exp_in [16];
    // y = ~b&~c | a&~b, bit i is the value at abc=i
    logic [7:0] truth_tbl = 8'b0011_0001;

    always #5 clk = ~clk;

    vector_sequencer_if #(.IN_W(3), .OUT_W(1), .DEPTH(16)) bus ();

    vector_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.dut_out = (~bus.dut_in[1] & ~bus.dut_in[0]) | (bus.dut_in[2] & ~bus.dut_in[1]);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] vin, input logic vexp);
        bus.load_valid = 1'b1;
        bus.load_data  = vseq_pack(vin, vexp);
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic load_truth(input int fault);
        logic e;
        for (int i = 0; i < 8; i++) begin
            exp_in[i] = 3'(i);
            e = truth_tbl[i];
            if (i == fault) e = ~e;
            load(3'(i), e);
        end
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic run(input int n, input int fault_idx, input bit mid_start);
        int pulses;
        int pidx;
        pulses = 0;
        pidx   = -1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("err_cleared_on_start", 32'(bus.err_count), 32'd0);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("dut_in_%0d", k), 32'(bus.dut_in), 32'(exp_in[k]));
            tick();
            if (bus.err_pulse) begin
                pulses++;
                pidx = k;
            end
            if (k == n - 1) chk("done_not_early", 32'(bus.done), 32'd0);
            if (mid_start && k == 2) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        chk("done_at_2n", 32'(bus.done), 32'd1);
        chk("busy_at_end", 32'(bus.busy), 32'd0);
        chk("pass", 32'(bus.pass), (fault_idx < 0) ? 32'd1 : 32'd0);
        chk("err_count", 32'(bus.err_count), (fault_idx < 0) ? 32'd0 : 32'd1);
        chk("err_pulses", 32'(pulses), (fault_idx < 0) ? 32'd0 : 32'd1);
        chk("first_err_valid", 32'(bus.first_err_valid), (fault_idx < 0) ? 32'd0 : 32'd1);
        if (fault_idx >= 0) begin
            chk("pulse_idx", 32'(pidx), 32'(fault_idx));
            chk("first_err_idx", 32'(bus.first_err_idx), 32'(fault_idx));
        end
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.clear      = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pass", 32'(bus.pass), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_vec_count", 32'(bus.vec_count), 32'd0);
        chk("rst_dut_in", 32'(bus.dut_in), 32'd0);
        chk("rst_first_err_valid", 32'(bus.first_err_valid), 32'd0);
        reset = 1'b0;
        tick();
        chk("load_ready_empty", 32'(bus.load_ready), 32'd1);

        // start with an empty table stays idle
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("empty_start_busy", 32'(bus.busy), 32'd0);
        chk("empty_start_done", 32'(bus.done), 32'd0);

        load_truth(-1);
        chk("vec_count_8", 32'(bus.vec_count), 32'd8);
        run(8, -1, 1'b0);

        do_clear();
        chk("clear_vec_count", 32'(bus.vec_count), 32'd0);
        chk("clear_done", 32'(bus.done), 32'd0);
        load_truth(5);
        run(8, 5, 1'b1);

        // full table; a 17th load must not land anywhere (it would corrupt entry 0)
        do_clear();
        for (int i = 0; i < 16; i++) begin
            exp_in[i] = 3'(i % 8);
            load(3'(i % 8), truth_tbl[i % 8]);
        end
        chk("full_vec_count", 32'(bus.vec_count), 32'd16);
        chk("full_load_ready", 32'(bus.load_ready), 32'd0);
        load(3'd0, 1'b0);
        chk("overflow_vec_count", 32'(bus.vec_count), 32'd16);
        run(16, -1, 1'b0);

        // abort in the APPLY cycle of idx 3
        do_clear();
        load_truth(1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_err_count", 32'(bus.err_count), 32'd1);
        chk("abort_first_err_idx", 32'(bus.first_err_idx), 32'd1);
        chk("abort_dut_in_held", 32'(bus.dut_in), 32'd3);
        run(8, 1, 1'b0);

        // asynchronous reset mid-run, after one mismatch has been counted
        do_clear();
        load_truth(0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("pre_reset_err_count", 32'(bus.err_count), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_vec_count", 32'(bus.vec_count), 32'd0);
        chk("arst_err_count", 32'(bus.err_count), 32'd0);
        chk("arst_dut_in", 32'(bus.dut_in), 32'd0);
        chk("arst_first_err_valid", 32'(bus.first_err_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // clear beats a simultaneous load in DONE
        load_truth(-1);
        run(8, -1, 1'b0);
        bus.clear      = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = vseq_pack(3'd7, 1'b1);
        tick();
        bus.clear      = 1'b0;
        bus.load_valid = 1'b0;
        chk("clr_load_vec_count", 32'(bus.vec_count), 32'd0);
        chk("clr_load_done", 32'(bus.done), 32'd0);
        chk("clr_load_pass", 32'(bus.pass), 32'd0);
        chk("clr_load_ready", 32'(bus.load_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
